// File: rtl/duty_window_averager.sv
`default_nettype none
// ============================================================================
// Module      : duty_window_averager
// Description : Batches 2**LOG2_WIN consecutive duty-cycle window counts and
//               produces the truncated average plus the batch min/max on a
//               valid/ready result port. A batch that completes while an
//               undelivered result is still pending is dropped and recorded
//               in a sticky overrun flag.
//
// Ports       : clk          system clock (rising edge)
//               rst_n        asynchronous active-low reset
//               enable       measurement enable (shared with the measurer)
//               count_in     duty count of the window just completed
//               window_done  one-cycle window-complete pulse
//               res_ready    consumer ready
//               res_valid    result available
//               res_avg      truncated batch average
//               res_min      smallest window count of the batch
//               res_max      largest window count of the batch
//               overrun      sticky: a completed batch was dropped
//               alarm_lo     avg below LO_THR  (DUTY_THRESHOLD_EN only)
//               alarm_hi     avg above HI_THR  (DUTY_THRESHOLD_EN only)
//
// Options     : `define DUTY_THRESHOLD_EN adds the alarm_lo/alarm_hi outputs.
//
// Revision    : 1.0 - initial release
// ============================================================================
module duty_window_averager #(
    parameter int CNT_W    = 8,
    parameter int LOG2_WIN = 2,
    parameter int LO_THR   = 64,
    parameter int HI_THR   = 192
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] count_in,
    input  logic             window_done,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_avg,
    output logic [CNT_W-1:0] res_min,
    output logic [CNT_W-1:0] res_max,
`ifdef DUTY_THRESHOLD_EN
    output logic             overrun,
    output logic             alarm_lo,
    output logic             alarm_hi
`else
    output logic             overrun
`endif
);

    localparam int SUM_W = CNT_W + LOG2_WIN;

    localparam logic [0:0]          c_st_idle   = 1'b0;
    localparam logic [0:0]          c_st_accum  = 1'b1;
    localparam logic [LOG2_WIN-1:0] c_widx_last = '1;

    // Thresholds must be ordered and representable in a CNT_W result.
    if ((LO_THR > HI_THR) || (HI_THR >= (1 << CNT_W))) begin : g_thr_chk
        $error("duty_window_averager: LO_THR/HI_THR out of range");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [0:0]          w_state_next;

    logic [SUM_W-1:0]    r_sum;
    logic [LOG2_WIN-1:0] r_widx;
    logic [CNT_W-1:0]    r_run_min;
    logic [CNT_W-1:0]    r_run_max;

    logic                r_res_valid;
    logic [CNT_W-1:0]    r_res_avg;
    logic [CNT_W-1:0]    r_res_min;
    logic [CNT_W-1:0]    r_res_max;
    logic                r_overrun;

    // Datapath candidates including the current sample
    logic [SUM_W-1:0]    w_sum_next;
    logic [CNT_W-1:0]    w_min_next;
    logic [CNT_W-1:0]    w_max_next;
    logic [CNT_W-1:0]    w_avg_next;

    // Control decodes
    logic                w_accept;
    logic                w_last;
    logic                w_xfer;
    logic                w_load;
    logic                w_drop;
    logic                w_leave;
    logic                w_acc_clear;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (enable)  w_state_next = c_st_accum;
            c_st_accum: if (!enable) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_accept    = 1'b0;
        w_leave     = 1'b0;
        w_acc_clear = 1'b1;
        if (r_state == c_st_accum) begin
            // enable dominates a coincident window_done: the sample is lost
            w_accept    = enable && window_done;
            w_leave     = !enable;
            w_acc_clear = !enable;
        end
        w_last = w_accept && (r_widx == c_widx_last);
        w_xfer = r_res_valid && res_ready;
        // A result slot freed by a transfer on this edge can take the new batch
        w_load = w_last && (!r_res_valid || w_xfer);
        w_drop = w_last && r_res_valid && !res_ready;
        if (w_last) begin
            w_acc_clear = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    assign w_sum_next = r_sum + {{LOG2_WIN{1'b0}}, count_in};
    assign w_min_next = (count_in < r_run_min) ? count_in : r_run_min;
    assign w_max_next = (count_in > r_run_max) ? count_in : r_run_max;
    // Dropping the low LOG2_WIN bits is the truncating divide by batch size
    assign w_avg_next = w_sum_next[SUM_W-1:LOG2_WIN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_widx    <= '0;
            r_run_min <= '1;
            r_run_max <= '0;
        end else if (w_acc_clear) begin
            r_sum     <= '0;
            r_widx    <= '0;
            r_run_min <= '1;
            r_run_max <= '0;
        end else if (w_accept) begin
            r_sum     <= w_sum_next;
            r_widx    <= r_widx + LOG2_WIN'(1);
            r_run_min <= w_min_next;
            r_run_max <= w_max_next;
        end
    end

    // ------------------------------------------------------------------------
    // Result port and overrun
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_avg   <= '0;
            r_res_min   <= '0;
            r_res_max   <= '0;
        end else if (w_load) begin
            r_res_valid <= 1'b1;
            r_res_avg   <= w_avg_next;
            r_res_min   <= w_min_next;
            r_res_max   <= w_max_next;
        end else if (w_xfer) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_leave) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_avg   = r_res_avg;
    assign res_min   = r_res_min;
    assign res_max   = r_res_max;
    assign overrun   = r_overrun;

`ifdef DUTY_THRESHOLD_EN
    // ------------------------------------------------------------------------
    // Threshold alarms, tracking only results that were actually loaded
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_lo_thr = LO_THR[CNT_W-1:0];
    localparam logic [CNT_W-1:0] c_hi_thr = HI_THR[CNT_W-1:0];

    logic r_alarm_lo;
    logic r_alarm_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm_lo <= 1'b0;
            r_alarm_hi <= 1'b0;
        end else if (w_load) begin
            r_alarm_lo <= (w_avg_next < c_lo_thr);
            r_alarm_hi <= (w_avg_next > c_hi_thr);
        end
    end

    assign alarm_lo = r_alarm_lo;
    assign alarm_hi = r_alarm_hi;
`endif

endmodule
`default_nettype wire

// File: tb/tb_duty_window_averager.sv
`default_nettype none
// ============================================================================
// Module      : tb_duty_window_averager
// Description : Directed bench for duty_window_averager. A batch-level model
//               (queue of accepted windows, integer average, min/max scan)
//               is checked against the DUT on every falling clock edge, and
//               literal expectations pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_window_averager;

    localparam int CNT_W    = 8;
    localparam int LOG2_WIN = 2;
    localparam int WIN      = 4;
    localparam int LO_THR   = 64;
    localparam int HI_THR   = 192;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             enable      = 1'b0;
    logic [CNT_W-1:0] count_in    = '0;
    logic             window_done = 1'b0;
    logic             res_ready   = 1'b0;
    logic             res_valid;
    logic [CNT_W-1:0] res_avg;
    logic [CNT_W-1:0] res_min;
    logic [CNT_W-1:0] res_max;
    logic             overrun;
`ifdef DUTY_THRESHOLD_EN
    logic             alarm_lo;
    logic             alarm_hi;
`endif

    int checks = 0;
    int errors = 0;

    duty_window_averager #(
        .CNT_W    (CNT_W),
        .LOG2_WIN (LOG2_WIN),
        .LO_THR   (LO_THR),
        .HI_THR   (HI_THR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .count_in    (count_in),
        .window_done (window_done),
        .res_ready   (res_ready),
        .res_valid   (res_valid),
        .res_avg     (res_avg),
        .res_min     (res_min),
        .res_max     (res_max),
`ifdef DUTY_THRESHOLD_EN
        .overrun     (overrun),
        .alarm_lo    (alarm_lo),
        .alarm_hi    (alarm_hi)
`else
        .overrun     (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Batch-level reference model
    // ------------------------------------------------------------------------
    int   m_q[$];
    bit   m_active = 1'b0;
    bit   m_valid  = 1'b0;
    bit   m_ovr    = 1'b0;
    int   m_avg    = 0;
    int   m_min    = 0;
    int   m_max    = 0;
    bit   m_alo    = 1'b0;
    bit   m_ahi    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_avg    = 0;
            m_min    = 0;
            m_max    = 0;
            m_alo    = 1'b0;
            m_ahi    = 1'b0;
        end else begin
            bit done;
            bit xfer;
            int s;
            int mn;
            int mx;
            done = 1'b0;
            xfer = m_valid && res_ready;
            s    = 0;
            mn   = (1 << CNT_W) - 1;
            mx   = 0;
            if (!m_active) begin
                if (enable) begin
                    m_active = 1'b1;
                    m_q.delete();
                end
            end else if (!enable) begin
                m_active = 1'b0;
                m_q.delete();
                m_ovr = 1'b0;
            end else if (window_done) begin
                m_q.push_back(int'(count_in));
                if (m_q.size() == WIN) begin
                    foreach (m_q[i]) begin
                        s = s + m_q[i];
                        if (m_q[i] < mn) mn = m_q[i];
                        if (m_q[i] > mx) mx = m_q[i];
                    end
                    done = 1'b1;
                    m_q.delete();
                end
            end
            if (done) begin
                if (!m_valid || xfer) begin
                    m_valid = 1'b1;
                    m_avg   = s / WIN;
                    m_min   = mn;
                    m_max   = mx;
                    m_alo   = (m_avg < LO_THR);
                    m_ahi   = (m_avg > HI_THR);
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("valid", 32'(res_valid), 32'(m_valid));
        chk("avg", 32'(res_avg), 32'(m_avg));
        chk("min", 32'(res_min), 32'(m_min));
        chk("max", 32'(res_max), 32'(m_max));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef DUTY_THRESHOLD_EN
        chk("alarm_lo", 32'(alarm_lo), 32'(m_alo));
        chk("alarm_hi", 32'(alarm_hi), 32'(m_ahi));
`endif
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic win(input int v);
        window_done = 1'b1;
        count_in    = v[CNT_W-1:0];
        @(negedge clk);
        window_done = 1'b0;
    endtask

    task automatic batch(input int a, input int b, input int c, input int d);
        win(a);
        win(b);
        win(c);
        win(d);
    endtask

    task automatic lit(input string tag, input int v, input int a, input int mn, input int mx);
        chk({tag, "_valid"}, 32'(res_valid), 32'(v));
        chk({tag, "_avg"},   32'(res_avg),   32'(a));
        chk({tag, "_min"},   32'(res_min),   32'(mn));
        chk({tag, "_max"},   32'(res_max),   32'(mx));
    endtask

    initial begin
        tick(2);
        lit("reset", 0, 0, 0, 0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Basic batches with a ready consumer
        res_ready = 1'b1;
        enable    = 1'b1;
        tick(1);
        batch(10, 20, 30, 40);
        lit("b1", 1, 25, 10, 40);
        tick(1);
        chk("b1_consumed", 32'(res_valid), 32'd0);
        batch(1, 1, 1, 2);
        lit("trunc", 1, 1, 1, 2);
        tick(1);
        batch(255, 255, 255, 255);
        lit("full", 1, 255, 255, 255);
        tick(1);

        // Consumer stalled across two batches
        res_ready = 1'b0;
        batch(5, 5, 5, 5);
        lit("stall1", 1, 5, 5, 5);
        batch(9, 9, 9, 9);
        lit("stall2", 1, 5, 5, 5);
        chk("ovr_set", 32'(overrun), 32'd1);
        res_ready = 1'b1;
        tick(1);
        chk("ovr_xfer_valid", 32'(res_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        enable = 1'b0;
        tick(1);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Partial batch discarded by enable low
        enable = 1'b1;
        tick(1);
        win(7);
        win(7);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(1);
        batch(100, 100, 100, 100);
        lit("discard", 1, 100, 100, 100);
        chk("discard_ovr", 32'(overrun), 32'd0);
        tick(1);

        // Completion coinciding with a transfer
        res_ready = 1'b0;
        batch(3, 3, 3, 3);
        win(8);
        win(8);
        win(8);
        res_ready = 1'b1;
        win(8);
        lit("coincide", 1, 8, 8, 8);
        chk("coincide_ovr", 32'(overrun), 32'd0);
        tick(1);

        // enable falling together with window_done loses that sample
        win(50);
        win(50);
        win(50);
        enable = 1'b0;
        win(50);
        enable = 1'b1;
        tick(1);
        batch(60, 60, 60, 60);
        lit("en_fall", 1, 60, 60, 60);
        tick(1);

        // Threshold region batches
        batch(40, 50, 60, 50);
        lit("thr_lo", 1, 50, 40, 60);
`ifdef DUTY_THRESHOLD_EN
        chk("alarm_lo_set", 32'(alarm_lo), 32'd1);
        chk("alarm_hi_clr", 32'(alarm_hi), 32'd0);
`endif
        tick(1);
        batch(200, 190, 210, 200);
        lit("thr_hi", 1, 200, 190, 210);
`ifdef DUTY_THRESHOLD_EN
        chk("alarm_lo_clr", 32'(alarm_lo), 32'd0);
        chk("alarm_hi_set", 32'(alarm_hi), 32'd1);
`endif
        tick(1);

        // Asynchronous reset while a result is pending and a batch is open
        res_ready = 1'b0;
        batch(11, 11, 11, 11);
        win(11);
        #2;
        rst_n = 1'b0;
        #1;
        lit("async_rst", 0, 0, 0, 0);
        chk("async_rst_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        batch(12, 13, 14, 15);
        lit("post_rst", 1, 13, 12, 15);
        res_ready = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/duty_window_averager.md
Name: duty_window_averager

Overview:
- Stage directly downstream of the duty-cycle measurement circuit.
- Consumes the per-window duty count and the window-complete pulse, and accumulates 2^LOG2_WIN consecutive windows.
- Each batch produces a truncated average plus min/max, presented on a valid/ready result interface to the display/readout logic.
- A result that cannot be delivered is dropped and flagged with a sticky overrun bit.

Parameters:
- CNT_W, 8: width of count_in and of the avg/min/max results.
- LOG2_WIN, 2: log2 of windows per batch; default gives 4 windows per batch.
- LO_THR, 64: low alarm threshold. Used only with DUTY_THRESHOLD_EN.
- HI_THR, 192: high alarm threshold. Used only with DUTY_THRESHOLD_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  measurement enable; must be the same signal that drives the measurement circuit.
- count_in  in  CNT_W  duty count of the window just completed.
- window_done  in  1  one-cycle window-complete pulse (measurement carry); count_in is valid in this cycle.
- res_ready  in  1  consumer ready.
- res_valid  out  1  result available.
- res_avg  out  CNT_W  batch average.
- res_min  out  CNT_W  smallest window count in the batch.
- res_max  out  CNT_W  largest window count in the batch.
- overrun  out  1  sticky flag: a completed batch was dropped.
- alarm_lo  out  1  only with DUTY_THRESHOLD_EN.
- alarm_hi  out  1  only with DUTY_THRESHOLD_EN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - sum=0, widx=0, run_min=all ones, run_max=0.
  - res_valid=0; res_avg/res_min/res_max=0; overrun=0; alarms=0.
- Internal widths: sum is CNT_W+LOG2_WIN bits and can never overflow (max 255*4=1020 at defaults). widx is LOG2_WIN bits.
- FSM, two states:
  - IDLE: window_done is ignored. enable=1 -> ACCUM, with sum/widx/min/max at their reset values.
  - ACCUM: enable=0 -> IDLE. The partial batch is discarded, any pending result is kept, and overrun is cleared.
- Accumulate, in ACCUM on each window_done=1 cycle:
  - sum += count_in.
  - run_min = min(run_min, count_in); run_max = max(run_max, count_in). Ties leave the value unchanged.
  - widx increments.
  - Back-to-back window_done pulses each count.
- Batch complete (window_done with widx == 2^LOG2_WIN-1):
  - At that same edge: res_avg = (sum+count_in) >> LOG2_WIN (truncated); res_min/res_max take the final values including count_in; res_valid=1.
  - Latency: outputs update at the clock edge that samples the final window_done.
  - At the same edge, accumulators reset to initial values and widx wraps to 0. Accumulation continues with no dead cycle.
- Handshake:
  - A transfer occurs at an edge where res_valid=1 and res_ready=1; res_valid falls after that edge.
  - res_avg/res_min/res_max are stable while res_valid=1.
  - res_ready is don't-care while res_valid=0.
- Simultaneous batch completion and transfer at the same edge: the new result loads and res_valid stays 1. This is not an overrun.
- Batch completes while res_valid=1 and res_ready=0:
  - The new result is dropped and the old result is held.
  - overrun is set. It clears only on reset or on exit to IDLE.
  - Accumulators still restart.
- enable falling in the same cycle as window_done: enable wins; the sample is discarded.
- Reset mid-batch or mid-handshake: everything returns to reset values immediately.

Optional Feature:
- Macro DUTY_THRESHOLD_EN.
- Defined:
  - alarm_lo/alarm_hi ports exist.
  - Registered at the same edge as each loaded result: alarm_lo = (new avg < LO_THR), alarm_hi = (new avg > HI_THR).
  - Both hold until the next loaded result and are not affected by dropped results.
  - Both are cleared on reset.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Windows 10,20,30,40 with res_ready=1 -> one cycle of res_valid=1 at the 4th window_done edge; avg=25, min=10, max=40.
- Windows 1,1,1,2 -> avg=1 (truncation), min=1, max=2.
- Four windows of 255 -> avg=255, max=255, min=255; no wrap.
- res_ready=0 across two batches (5,5,5,5 then 9,9,9,9) -> avg=5 held, overrun=1. Then res_ready=1 -> one transfer, res_valid=0, overrun stays 1 until enable=0.
- Two windows of 7, enable low for 3 cycles, then four windows of 100 -> avg=100, min=100; overrun=0.
- With DUTY_THRESHOLD_EN: batch avg 50 -> alarm_lo=1, alarm_hi=0. Next batch avg 200 -> alarm_lo=0, alarm_hi=1.
